// File: rtl/font_pkg.sv
// Shared font constants, glyph FSM state type and ROM address helper
// for the 8x16 glyph reader.
package font_pkg;
  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 8;
  localparam int FONT_AW    = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_EMIT} glyph_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } col_beat_t;

  function automatic logic [FONT_AW-1:0] glyph_addr(input logic [7:0] code, input logic [3:0] row);
    return {code, row};
  endfunction
endpackage

// File: rtl/font_glyph_reader_if.sv
// Glyph reader bus: character request, font ROM pins and column stream.
// slave is the reader's view; master is the surrounding system's view.
interface font_glyph_reader_if;
  import font_pkg::*;

  logic               char_valid;
  logic [7:0]         char_code;
  logic               char_ready;
  logic [FONT_AW-1:0] rom_ad;
  logic               rom_ce;
  logic               rom_oce;
  logic [7:0]         rom_dout;
  logic               col_valid;
  logic               col_ready;
  logic [7:0]         col_data;
  logic               col_last;
  logic               busy;

  modport slave (
    input  char_valid, char_code, rom_dout, col_ready,
    output char_ready, rom_ad, rom_ce, rom_oce, col_valid, col_data, col_last, busy
  );

  modport master (
    output char_valid, char_code, rom_dout, col_ready,
    input  char_ready, rom_ad, rom_ce, rom_oce, col_valid, col_data, col_last, busy
  );
endinterface

// File: rtl/font_glyph_reader.sv
// Reads one 8x16 glyph (16 row bytes) from the font ROM and re-emits it as
// 16 column bytes in SSD1306 page order: page 0 cols 0-7, then page 1 cols 0-7.
module font_glyph_reader
  import font_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  font_glyph_reader_if.slave bus
);

  glyph_state_t state_q, state_d;
  logic [7:0]   code_q;
  logic [3:0]   row_q;
  logic [3:0]   k_q;
  logic [GLYPH_ROWS-1:0][GLYPH_COLS-1:0] rowbuf;

  // Read tags ride alongside the ROM latency; stage ROM_LATENCY lines up with rom_dout.
  logic [ROM_LATENCY:1]      vld_pipe;
  logic [ROM_LATENCY:1][3:0] tag_pipe;

  logic      issue;
  logic      accept;
  logic      col_hs;
  logic      last_back;
  col_beat_t beat;

  assign issue     = (state_q == ST_FETCH);
  assign accept    = (state_q == ST_IDLE) && bus.char_valid;
  assign col_hs    = (state_q == ST_EMIT) && bus.col_ready;
  assign last_back = vld_pipe[ROM_LATENCY] && (tag_pipe[ROM_LATENCY] == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      k_q      <= '0;
      vld_pipe <= '0;
    end else begin
      state_q     <= state_d;
      vld_pipe[1] <= issue;
      for (int i = 2; i <= ROM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (accept) begin
        row_q <= '0;
        k_q   <= '0;
      end else begin
        if (issue && row_q != 4'hF) row_q <= row_q + 4'd1;
        if (col_hs && k_q != 4'hF)  k_q   <= k_q + 4'd1;
      end
    end
  end

  // Data-path state carries no reset; an aborted glyph's leftovers are never emitted.
  always_ff @(posedge clk) begin
    if (accept) code_q <= bus.char_code;
    tag_pipe[1] <= row_q;
    for (int i = 2; i <= ROM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    if (vld_pipe[ROM_LATENCY]) rowbuf[tag_pipe[ROM_LATENCY]] <= bus.rom_dout;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.char_valid)              state_d = ST_FETCH;
      ST_FETCH: if (row_q == 4'hF)               state_d = ST_DRAIN;
      ST_DRAIN: if (last_back)                   state_d = ST_EMIT;
      ST_EMIT:  if (col_hs && k_q == 4'hF)       state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.char_ready = (state_q == ST_IDLE);
    bus.busy       = (state_q != ST_IDLE);
    bus.rom_ce     = issue;
    bus.rom_oce    = issue;
    bus.rom_ad     = issue ? glyph_addr(code_q, row_q) : '0;
    bus.col_valid  = (state_q == ST_EMIT);
    beat           = '0;
    if (state_q == ST_EMIT) begin
      // Bit b of column c in page p is pixel (7-c) of row 8p+b.
      for (int b = 0; b < GLYPH_COLS; b++)
        beat.data[b] = rowbuf[{k_q[3], b[2:0]}][3'd7 - k_q[2:0]];
      beat.last = (k_q == 4'hF);
    end
    bus.col_data = beat.data;
    bus.col_last = beat.last;
  end

endmodule

// File: tb/tb_font_glyph_reader.sv
// Scoreboard bench for font_glyph_reader: drivers push expected ROM addresses
// and column bytes; a negedge monitor pops and compares on every DUT output.
module tb_font_glyph_reader;
  import font_pkg::*;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mode_a = 0, mode_b = 2;
  bit   bp_mode = 0;
  bit   done_b = 0;

  typedef struct { logic [11:0] ad; int cyc; } ad_exp_t;
  typedef struct { logic [7:0] data; logic last; int cyc; } col_exp_t;

  ad_exp_t  ad_q[2][$];
  col_exp_t col_q[2][$];
  logic       stall_prev[2];
  logic [8:0] stall_beat[2];
  logic       last_prev[2];

  logic [7:0] tbl_top[16], tbl_left[16], tbl_l2[16];
  logic [7:0] ra1, rb1, rb2;

  font_glyph_reader_if ia();
  font_glyph_reader_if ib();

  font_glyph_reader #(.ROM_LATENCY(1)) dut_a (.clk(clk), .reset(reset_a), .bus(ia));
  font_glyph_reader #(.ROM_LATENCY(2)) dut_b (.clk(clk), .reset(reset_b), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(input int mode, input logic [3:0] row);
    case (mode)
      0:       rom_fn = (row == 4'd0) ? 8'hFF : 8'h00;
      1:       rom_fn = 8'h80;
      default: rom_fn = {4'h0, row};
    endcase
  endfunction

  // ROM models: registered read, one and two cycles deep.
  always @(posedge clk) begin
    if (ia.rom_ce) ra1 <= rom_fn(mode_a, ia.rom_ad[3:0]);
    if (ib.rom_ce) rb1 <= rom_fn(mode_b, ib.rom_ad[3:0]);
    rb2 <= rb1;
  end
  assign ia.rom_dout = ra1;
  assign ib.rom_dout = rb2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h expected=no output (cycle %0d)", name, act, cyc);
  endtask

  task automatic mon(input int id, input logic rce, input logic roce, input logic [11:0] rad,
                     input logic cv, input logic cr, input logic [7:0] cd, input logic cl,
                     input logic crdy, input logic bsy);
    ad_exp_t  ea;
    col_exp_t ec;
    if (last_prev[id]) begin
      chk("ready_after_last", {31'd0, crdy}, 32'd1);
      chk("busy_after_last", {31'd0, bsy}, 32'd0);
    end
    last_prev[id] = 1'b0;
    if (stall_prev[id]) begin
      chk("stall_valid", {31'd0, cv}, 32'd1);
      chk("stall_hold", {23'd0, cd, cl}, {23'd0, stall_beat[id]});
    end
    stall_prev[id] = cv && !cr;
    stall_beat[id] = {cd, cl};
    if (rce) begin
      chk("rom_oce", {31'd0, roce}, 32'd1);
      if (ad_q[id].size() == 0) unexpected("rom_ad_extra", {20'd0, rad});
      else begin
        ea = ad_q[id].pop_front();
        chk("rom_ad", {20'd0, rad}, {20'd0, ea.ad});
        chk("rom_ad_cycle", cyc, ea.cyc);
      end
    end
    if (cv && cr) begin
      if (col_q[id].size() == 0) unexpected("col_extra", {24'd0, cd});
      else begin
        ec = col_q[id].pop_front();
        chk("col_data", {24'd0, cd}, {24'd0, ec.data});
        chk("col_last", {31'd0, cl}, {31'd0, ec.last});
        if (ec.cyc >= 0) chk("col_cycle", cyc, ec.cyc);
      end
      last_prev[id] = cl;
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.rom_ce, ia.rom_oce, ia.rom_ad, ia.col_valid, ia.col_ready, ia.col_data,
        ia.col_last, ia.char_ready, ia.busy);
    mon(1, ib.rom_ce, ib.rom_oce, ib.rom_ad, ib.col_valid, ib.col_ready, ib.col_data,
        ib.col_last, ib.char_ready, ib.busy);
  end

  // Downstream ready: 1,0,0,1,0,0... in backpressure mode, otherwise always 1.
  initial begin
    int p = 0;
    ia.col_ready = 1'b1;
    ib.col_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ia.col_ready = bp_mode ? (p % 3 == 0) : 1'b1;
      p++;
    end
  end

  function automatic logic rdy(input int id);
    return (id == 0) ? ia.char_ready : ib.char_ready;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [7:0] code);
    if (id == 0) begin ia.char_valid = v; ia.char_code = code; end
    else         begin ib.char_valid = v; ib.char_code = code; end
  endtask

  task automatic send(input int id, input logic [7:0] code, input logic [7:0] cols[16], output int t);
    int n = 0;
    int lat = (id == 0) ? 1 : 2;
    col_exp_t ec;
    @(negedge clk);
    #1;
    set_req(id, 1'b1, code);
    while (!rdy(id) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    t = cyc;
    if (n >= 300) begin
      unexpected("char_ready_timeout", code);
      t = -1;
    end else begin
      for (int r = 0; r < 16; r++) ad_q[id].push_back('{ad: {code, r[3:0]}, cyc: t + 1 + r});
      for (int k = 0; k < 16; k++) begin
        ec.data = cols[k];
        ec.last = (k == 15);
        ec.cyc  = bp_mode ? -1 : t + 17 + lat + k;
        col_q[id].push_back(ec);
      end
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while ((ad_q[id].size() != 0 || col_q[id].size() != 0 || !rdy(id)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) unexpected("glyph_timeout", col_q[id].size());
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag, input logic crdy, input logic bsy, input logic cv,
                          input logic cl, input logic [7:0] cd, input logic rce, input logic roce,
                          input logic [11:0] rad);
    chk({tag, "_char_ready"}, {31'd0, crdy}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bsy}, 32'd0);
    chk({tag, "_col_valid"}, {31'd0, cv}, 32'd0);
    chk({tag, "_col_last"}, {31'd0, cl}, 32'd0);
    chk({tag, "_col_data"}, {24'd0, cd}, 32'd0);
    chk({tag, "_rom_ce"}, {31'd0, rce}, 32'd0);
    chk({tag, "_rom_oce"}, {31'd0, roce}, 32'd0);
    chk({tag, "_rom_ad"}, {20'd0, rad}, 32'd0);
  endtask

  // Latency-2 instance: identity rows, first column expected at T+19.
  initial begin
    int t;
    @(negedge reset_b);
    send(1, 8'h00, tbl_l2, t);
    wait_idle(1);
    done_b = 1;
  end

  initial begin
    int t, t2, n;
    for (int k = 0; k < 16; k++) begin
      tbl_top[k]  = (k < 8) ? 8'h01 : 8'h00;
      tbl_left[k] = (k == 0 || k == 8) ? 8'hFF : 8'h00;
    end
    tbl_l2 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hCC, 8'hAA,
               8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0, 8'hCC, 8'hAA};
    stall_prev = '{1'b0, 1'b0};
    last_prev  = '{1'b0, 1'b0};
    reset_a = 1'b1;
    reset_b = 1'b1;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk_idle("rst_a", ia.char_ready, ia.busy, ia.col_valid, ia.col_last, ia.col_data,
             ia.rom_ce, ia.rom_oce, ia.rom_ad);
    chk_idle("rst_b", ib.char_ready, ib.busy, ib.col_valid, ib.col_last, ib.col_data,
             ib.rom_ce, ib.rom_oce, ib.rom_ad);
    #2;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Solid top row
    mode_a = 0;
    send(0, 8'h41, tbl_top, t);
    wait_idle(0);

    // Left column lit
    mode_a = 1;
    send(0, 8'h20, tbl_left, t);
    wait_idle(0);

    // Backpressure
    mode_a = 0;
    bp_mode = 1;
    send(0, 8'h42, tbl_top, t);
    wait_idle(0);
    bp_mode = 0;

    // Request held while busy: accepted once, the cycle the first glyph returns to IDLE
    mode_a = 1;
    send(0, 8'h41, tbl_left, t);
    send(0, 8'h55, tbl_left, t2);
    chk("busy_accept_cycle", t2, t + 34);
    wait_idle(0);
    repeat (10) @(negedge clk);

    // Mid-FETCH reset, then a fresh glyph
    mode_a = 0;
    send(0, 8'h7E, tbl_top, t);
    while (cyc < t + 10) @(negedge clk);
    #2;
    reset_a = 1'b1;
    @(posedge clk);
    #1;
    reset_a = 1'b0;
    ad_q[0].delete();
    col_q[0].delete();
    @(negedge clk);
    chk_idle("midrst", ia.char_ready, ia.busy, ia.col_valid, ia.col_last, ia.col_data,
             ia.rom_ce, ia.rom_oce, ia.rom_ad);
    repeat (30) @(negedge clk);
    send(0, 8'h30, tbl_top, t);
    wait_idle(0);

    n = 0;
    while (!done_b && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) unexpected("lat2_timeout", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
